// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multicycle control path.
package legv8_ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        EXC
    } state_t;

    // Instruction classes as seen by the sequencer
    typedef enum logic [2:0] {
        OP_R,
        OP_LDUR,
        OP_STUR,
        OP_CBZ,
        OP_ILL
    } op_class_t;

    // Opcode field instr[31:21]
    localparam logic [10:0] OPC_ADD    = 11'b10001011000;
    localparam logic [10:0] OPC_SUB    = 11'b11001011000;
    localparam logic [10:0] OPC_AND    = 11'b10001010000;
    localparam logic [10:0] OPC_ORR    = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR   = 11'b11111000010;
    localparam logic [10:0] OPC_STUR   = 11'b11111000000;
    // CBZ only fixes the top 8 bits; the low 3 bits belong to the immediate
    localparam logic [7:0]  OPC_CBZ_HI = 8'b10110100;

    // ALU operation select
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    // Exception cause
    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_IMEM_TO = 2'b10;
    localparam logic [1:0] EXC_DMEM_TO = 2'b11;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decoder: classifies instr[31:21] and picks the ALU
// operation. Kept separate so pipelined control can reuse it.
module op_decoder
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] instr,
    output op_class_t   op_class,
    output logic [3:0]  alu_ctrl
);

    // Map opcode to class and ALU op; unknown opcodes are illegal
    always_comb begin
        op_class = OP_ILL;
        alu_ctrl = ALU_AND;
        if (instr[10:3] == OPC_CBZ_HI) begin
            op_class = OP_CBZ;
            alu_ctrl = ALU_PASSB;
        end else begin
            case (instr)
                OPC_ADD: begin
                    op_class = OP_R;
                    alu_ctrl = ALU_ADD;
                end
                OPC_SUB: begin
                    op_class = OP_R;
                    alu_ctrl = ALU_SUB;
                end
                OPC_AND: begin
                    op_class = OP_R;
                    alu_ctrl = ALU_AND;
                end
                OPC_ORR: begin
                    op_class = OP_R;
                    alu_ctrl = ALU_ORR;
                end
                OPC_LDUR: begin
                    op_class = OP_LDUR;
                    alu_ctrl = ALU_ADD;
                end
                OPC_STUR: begin
                    op_class = OP_STUR;
                    alu_ctrl = ALU_ADD;
                end
                default: begin
                    op_class = OP_ILL;
                    alu_ctrl = ALU_AND;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with variable-latency
// memory handshakes, a memory watchdog, halt/resume, a retired-instruction
// counter and a sticky exception state.
// Parameter constraints: TIMEOUT >= 2 and 2**TO_W > TIMEOUT.
module multicycle_controller
    import legv8_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [10:0]      instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             halt,
    output logic             imem_req,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             reg2loc,
    output logic             AluSrc,
    output logic             memtoReg,
    output logic             Branch,
    output logic             regWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic [3:0]       AluControl,
    output logic [CNT_W-1:0] retired,
    output logic             idle,
    output logic             exc,
    output logic [1:0]       exc_code
);

    // Watchdog value on the last permitted waiting cycle
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    op_class_t         cls;
    logic [3:0]        alu_op;
    logic [TO_W-1:0]   wdog;
    logic [CNT_W-1:0]  retired_cnt;
    logic [1:0]        exc_cause;

    op_class_t         dec_class;
    logic [3:0]        dec_alu;

    op_decoder u_op_decoder (
        .instr    (instr),
        .op_class (dec_class),
        .alu_ctrl (dec_alu)
    );

    // Sequencer, latched opcode class, watchdog, retire counter and cause
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cls         <= OP_R;
            alu_op      <= ALU_AND;
            wdog        <= '0;
            retired_cnt <= '0;
            exc_cause   <= EXC_NONE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!halt) begin
                        state <= FETCH;
                        wdog  <= '0;
                    end
                end
                FETCH: begin
                    // A ready on the last permitted cycle still wins
                    if (imem_ready) begin
                        state <= DECODE;
                    end else if (wdog == WD_LAST) begin
                        state     <= EXC;
                        exc_cause <= EXC_IMEM_TO;
                    end else begin
                        wdog <= wdog + TO_W'(1);
                    end
                end
                DECODE: begin
                    cls    <= dec_class;
                    alu_op <= dec_alu;
                    if (dec_class == OP_ILL) begin
                        state     <= EXC;
                        exc_cause <= EXC_ILLEGAL;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    unique case (cls)
                        OP_CBZ: begin
                            retired_cnt <= retired_cnt + CNT_W'(1);
                            state       <= halt ? IDLE : FETCH;
                            wdog        <= '0;
                        end
                        OP_LDUR, OP_STUR: begin
                            state <= MEM;
                            wdog  <= '0;
                        end
                        default: begin
                            state <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (dmem_ready) begin
                        if (cls == OP_STUR) begin
                            retired_cnt <= retired_cnt + CNT_W'(1);
                            state       <= halt ? IDLE : FETCH;
                            wdog        <= '0;
                        end else begin
                            state <= WB;
                        end
                    end else if (wdog == WD_LAST) begin
                        state     <= EXC;
                        exc_cause <= EXC_DMEM_TO;
                    end else begin
                        wdog <= wdog + TO_W'(1);
                    end
                end
                WB: begin
                    retired_cnt <= retired_cnt + CNT_W'(1);
                    state       <= halt ? IDLE : FETCH;
                    wdog        <= '0;
                end
                EXC: begin
                    // Sticky until reset; counter and cause frozen
                    state <= EXC;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore control decode from the state and latched class; only the
    // fetch strobes follow imem_ready so the IR loads in the ready cycle.
    // AluControl is driven only in EXEC, where the ALU result is consumed.
    always_comb begin
        imem_req   = (state == FETCH);
        irWrite    = (state == FETCH) && imem_ready;
        pcWrite    = (state == FETCH) && imem_ready;
        reg2loc    = (state == DECODE) && ((dec_class == OP_STUR) || (dec_class == OP_CBZ));
        AluSrc     = (state == EXEC) && ((cls == OP_LDUR) || (cls == OP_STUR));
        AluControl = (state == EXEC) ? alu_op : ALU_AND;
        Branch     = (state == EXEC) && (cls == OP_CBZ);
        memRead    = (state == MEM) && (cls == OP_LDUR);
        memWrite   = (state == MEM) && (cls == OP_STUR);
        regWrite   = (state == WB);
        memtoReg   = (state == WB) && (cls == OP_LDUR);
        idle       = (state == IDLE);
        exc        = (state == EXC);
        exc_code   = exc_cause;
        retired    = retired_cnt;
    end

    // The exception state never drives datapath controls
    always_ff @(posedge CLOCK_50) begin
        if (reset && exc) begin
            assert (!(imem_req || memRead || memWrite || regWrite || Branch))
                else $error("controls active in exception state");
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the driver expands each randomly chosen instruction into
// its expected per-cycle control sequence and queues it; a negedge monitor
// pops and compares against the DUT outputs.
module tb_multicycle_controller;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned TO_W    = 5;

    localparam int K_ADD  = 0;
    localparam int K_SUB  = 1;
    localparam int K_AND  = 2;
    localparam int K_ORR  = 3;
    localparam int K_LDUR = 4;
    localparam int K_STUR = 5;
    localparam int K_CBZ  = 6;
    localparam int K_ILL  = 7;

    typedef struct packed {
        logic             imem_req;
        logic             ir_write;
        logic             pc_write;
        logic             reg2loc;
        logic             alu_src;
        logic             memto_reg;
        logic             branch;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic [3:0]       alu;
        logic [CNT_W-1:0] ret;
        logic             idle;
        logic             exc;
        logic [1:0]       code;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [10:0]      instr = '0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             halt = 1'b0;
    logic             imem_req, irWrite, pcWrite, reg2loc, AluSrc, memtoReg;
    logic             Branch, regWrite, memRead, memWrite, idle, exc;
    logic [3:0]       AluControl;
    logic [CNT_W-1:0] retired;
    logic [1:0]       exc_code;

    vec_t             exp_q[$];
    string            tag_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc_no = 0;
    logic [CNT_W-1:0] m_ret = '0;

    always #5 clk = ~clk;

    multicycle_controller #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .instr      (instr),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .halt       (halt),
        .imem_req   (imem_req),
        .irWrite    (irWrite),
        .pcWrite    (pcWrite),
        .reg2loc    (reg2loc),
        .AluSrc     (AluSrc),
        .memtoReg   (memtoReg),
        .Branch     (Branch),
        .regWrite   (regWrite),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .AluControl (AluControl),
        .retired    (retired),
        .idle       (idle),
        .exc        (exc),
        .exc_code   (exc_code)
    );

    // Monitor: compare every queued expectation on the falling edge
    always @(negedge clk) begin
        vec_t  got;
        vec_t  want;
        string tag;
        cyc_no++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = '{imem_req, irWrite, pcWrite, reg2loc, AluSrc, memtoReg, Branch,
                     regWrite, memRead, memWrite, AluControl, retired, idle, exc, exc_code};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s cycle=%0d got=%b want=%b", tag, cyc_no, got, want);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    function automatic logic [10:0] rw();
        return 11'($urandom);
    endfunction

    function automatic vec_t z();
        vec_t v;
        v     = '0;
        v.ret = m_ret;
        return v;
    endfunction

    function automatic logic [10:0] opc(input int k);
        case (k)
            K_ADD:   return 11'b10001011000;
            K_SUB:   return 11'b11001011000;
            K_AND:   return 11'b10001010000;
            K_ORR:   return 11'b10101010000;
            K_LDUR:  return 11'b11111000010;
            K_STUR:  return 11'b11111000000;
            K_CBZ:   return {8'b10110100, 3'($urandom)};
            default: begin
                case ($urandom % 4)
                    0:       return 11'b11111111111;
                    1:       return 11'b00000000000;
                    2:       return 11'b10001011001;
                    default: return 11'b10110101000;
                endcase
            end
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input int k);
        case (k)
            K_SUB:   return 4'b0110;
            K_AND:   return 4'b0000;
            K_ORR:   return 4'b0001;
            K_CBZ:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    // One clock: drive this cycle's inputs and queue the expected outputs
    task automatic cyc(input vec_t v, input string tag, input logic ir, input logic dr,
                       input logic hl, input logic [10:0] ins, input logic rs);
        @(posedge clk);
        #1;
        reset      = rs;
        imem_ready = ir;
        dmem_ready = dr;
        halt       = hl;
        instr      = ins;
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset();
        vec_t v;
        m_ret  = '0;
        v      = z();
        v.idle = 1'b1;
        cyc(v, "reset", rb(), rb(), rb(), rw(), 1'b0);
        cyc(v, "reset", rb(), rb(), rb(), rw(), 1'b0);
        cyc(v, "idle_release", rb(), rb(), 1'b0, rw(), 1'b1);
    endtask

    // fw/mw: ready-low cycles before the handshake; >= TIMEOUT means it never
    // comes. eh: halt at instruction end. ab: abandon after the MEM waits.
    task automatic do_instr(input int k, input int fw, input int mw, input logic eh,
                            input logic ab);
        vec_t        v;
        logic [10:0] op;
        logic        st;
        op = opc(k);
        st = (k == K_STUR);
        for (int i = 0; i < fw && i < int'(TIMEOUT); i++) begin
            v          = z();
            v.imem_req = 1'b1;
            cyc(v, "fetch_wait", 1'b0, rb(), rb(), rw(), 1'b1);
        end
        if (fw >= int'(TIMEOUT)) return;
        v          = z();
        v.imem_req = 1'b1;
        v.ir_write = 1'b1;
        v.pc_write = 1'b1;
        cyc(v, "fetch", 1'b1, rb(), rb(), rw(), 1'b1);
        v         = z();
        v.reg2loc = (k == K_STUR) || (k == K_CBZ);
        cyc(v, "decode", rb(), rb(), rb(), op, 1'b1);
        if (k == K_ILL) return;
        v     = z();
        v.alu = alu_of(k);
        if (k == K_CBZ) begin
            v.branch = 1'b1;
            cyc(v, "exec_cbz", rb(), rb(), eh, rw(), 1'b1);
            m_ret++;
            return;
        end
        if (k == K_LDUR || st) begin
            v.alu_src = 1'b1;
            cyc(v, "exec_mem", rb(), rb(), rb(), rw(), 1'b1);
            for (int i = 0; i < mw && i < int'(TIMEOUT); i++) begin
                v           = z();
                v.mem_read  = !st;
                v.mem_write = st;
                cyc(v, "mem_wait", rb(), 1'b0, rb(), rw(), 1'b1);
            end
            if (mw >= int'(TIMEOUT) || ab) return;
            v           = z();
            v.mem_read  = !st;
            v.mem_write = st;
            if (st) begin
                cyc(v, "mem_store", rb(), 1'b1, eh, rw(), 1'b1);
                m_ret++;
                return;
            end
            cyc(v, "mem_load", rb(), 1'b1, rb(), rw(), 1'b1);
        end else begin
            cyc(v, "exec_r", rb(), rb(), rb(), rw(), 1'b1);
        end
        v           = z();
        v.reg_write = 1'b1;
        v.memto_reg = (k == K_LDUR);
        cyc(v, "wb", rb(), rb(), eh, rw(), 1'b1);
        m_ret++;
    endtask

    // After a halted end: park in IDLE for n cycles, releasing halt on the last
    task automatic park(input int n);
        vec_t v;
        v      = z();
        v.idle = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc(v, "idle_halt", rb(), rb(), (i < n - 1), rw(), 1'b1);
        end
    endtask

    task automatic exc_hold(input logic [1:0] code, input int n);
        vec_t v;
        v      = z();
        v.exc  = 1'b1;
        v.code = code;
        for (int i = 0; i < n; i++) begin
            cyc(v, "exc_hold", rb(), rb(), rb(), rw(), 1'b1);
        end
    endtask

    initial begin
        int k;
        int fw;
        int mw;
        logic eh;

        do_reset();
        // Back-to-back ADDs with ready tied high
        do_instr(K_ADD, 0, 0, 1'b0, 1'b0);
        do_instr(K_ADD, 0, 0, 1'b0, 1'b0);
        // LDUR with a 3-cycle data wait, then STUR and CBZ
        do_instr(K_LDUR, 0, 3, 1'b0, 1'b0);
        do_instr(K_STUR, 0, 0, 1'b0, 1'b0);
        do_instr(K_CBZ, 0, 0, 1'b0, 1'b0);
        // Halt at the end of a waiting store, then resume
        do_instr(K_STUR, 1, 2, 1'b1, 1'b0);
        park(3);
        // Ready arriving on the last permitted wait cycle
        do_instr(K_ORR, int'(TIMEOUT) - 1, 0, 1'b0, 1'b0);
        do_instr(K_LDUR, 2, int'(TIMEOUT) - 1, 1'b0, 1'b0);
        // Random legal traffic; wraps the 4-bit retire counter several times
        for (int n = 0; n < 60; n++) begin
            k  = int'($urandom % 7);
            fw = int'($urandom % 4);
            mw = int'($urandom % 5);
            eh = ($urandom % 4) == 0;
            do_instr(k, fw, mw, eh, 1'b0);
            if (eh) park(1 + int'($urandom % 3));
        end
        // Illegal opcode
        do_instr(K_ILL, 1, 0, 1'b0, 1'b0);
        exc_hold(2'b01, 20);
        do_reset();
        // Instruction fetch timeout
        do_instr(K_ADD, int'(TIMEOUT), 0, 1'b0, 1'b0);
        exc_hold(2'b10, 20);
        do_reset();
        // Data memory timeout on a store
        do_instr(K_SUB, 0, 0, 1'b0, 1'b0);
        do_instr(K_STUR, 0, int'(TIMEOUT), 1'b0, 1'b0);
        exc_hold(2'b11, 20);
        do_reset();
        // Reset in the middle of a load's memory wait
        do_instr(K_AND, 0, 0, 1'b0, 1'b0);
        do_instr(K_LDUR, 0, 2, 1'b0, 1'b1);
        do_reset();
        do_instr(K_CBZ, 2, 0, 1'b0, 1'b0);
        do_instr(K_LDUR, 0, 1, 1'b1, 1'b0);
        park(2);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
